// File: rtl/gpio_port.sv
// gpio_port: WIDTH-bit register-mapped GPIO with synchronised, optionally debounced inputs and edge IRQ.
// Define GPIO_PORT_DEBOUNCE_EN to build the prescaler and per-bit debounce counters.
`default_nettype none

module gpio_port #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEB_DIV = 4,
    parameter int unsigned      DEB_LEN = 3,
    parameter logic [WIDTH-1:0] RST_OUT = '0,
    parameter logic [WIDTH-1:0] RST_IN  = '1
) (
    input  logic             clk_i,
    input  logic             res_n_i,
    input  logic [1:0]       addr_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [WIDTH-1:0] porti_i,
    output logic [WIDTH-1:0] porto_o,
    output logic             irq_o
);

    localparam logic [1:0] ADDR_OUT  = 2'd0;
    localparam logic [1:0] ADDR_IN   = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_IEN  = 2'd3;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic             irq_q;

    logic wr_out;
    logic wr_edge;
    logic wr_ien;

    assign wr_out  = we_i && (addr_i == ADDR_OUT);
    assign wr_edge = we_i && (addr_i == ADDR_EDGE);
    assign wr_ien  = we_i && (addr_i == ADDR_IEN);

`ifdef GPIO_PORT_DEBOUNCE_EN
    localparam int unsigned    PW      = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int unsigned    CW      = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DEB_DIV - 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_LEN - 1);

    logic [PW-1:0] pre_q;
    logic          tick;
    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    assign tick = (pre_q == PRE_MAX);

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

    // A bit is accepted only after DEB_LEN consecutive ticks that all disagree with stable.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic [1:0] deb_cfg_unused;
    assign deb_cfg_unused = {(DEB_DIV == 0), (DEB_LEN == 0)};
    assign stable_d       = sync2_q;
`endif

    // A fresh stable change beats a same-cycle write-1-to-clear.
    assign edge_d = (edge_q & ~(wr_edge ? wdata_i : '0)) | (stable_d ^ stable_q);

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            case (addr_i)
                ADDR_OUT:  rdata_d = out_q;
                ADDR_IN:   rdata_d = stable_q;
                ADDR_EDGE: rdata_d = edge_q;
                default:   rdata_d = ien_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            out_q    <= RST_OUT;
            sync1_q  <= RST_IN;
            sync2_q  <= RST_IN;
            stable_q <= RST_IN;
            edge_q   <= '0;
            ien_q    <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= porti_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            rdata_q  <= rdata_d;
            irq_q    <= |(edge_q & ien_q);
            if (wr_out) begin
                out_q <= wdata_i;
            end
            if (wr_ien) begin
                ien_q <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign porto_o = out_q;
    assign irq_o   = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_port.sv
// tb_gpio_port: scoreboard bench for gpio_port; expectations follow GPIO_PORT_DEBOUNCE_EN.
`default_nettype none

module tb_gpio_port;

    localparam int DIV = 4;
    localparam int LEN = 3;
`ifdef GPIO_PORT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam logic [1:0] A_OUT  = 2'd0;
    localparam logic [1:0] A_IN   = 2'd1;
    localparam logic [1:0] A_EDGE = 2'd2;
    localparam logic [1:0] A_IEN  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] addr = '0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic [7:0] porti = 8'hFF;
    logic [7:0] porto;
    logic       irq;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp;

    gpio_port #(.WIDTH(8), .DEB_DIV(DIV), .DEB_LEN(LEN), .RST_OUT(8'h00), .RST_IN(8'hFF)) dut (
        .clk_i(clk), .res_n_i(rst_n), .addr_i(addr), .we_i(we), .re_i(re),
        .wdata_i(wdata), .rdata_o(rdata), .porti_i(porti), .porto_o(porto), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the prescaler phase is derived from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issues a one-cycle read and queues its expected result; returns when RDATA is valid.
    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        addr = a; re = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; porti = 8'hFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (porto !== 8'h00) begin n_fail++; $display("FAIL reset_porto: got %h want 00", porto); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_IN, 8'hFF);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL reset_in: got %h want %h", rdata, exp); end
        rd(A_EDGE, 8'h00);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL reset_edge: got %h want %h", rdata, exp); end
    endtask

    task automatic test_output;
        wr(A_OUT, 8'hA5);
        n_cmp++; if (porto !== 8'hA5) begin n_fail++; $display("FAIL out_porto: got %h want a5", porto); end
        rd(A_OUT, 8'hA5);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL out_read: got %h want %h", rdata, exp); end
        // Same-cycle read and write: read sees the old value, write still lands.
        addr = A_OUT; wdata = 8'h3C; we = 1'b1; re = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL rw_collide_rdata: got %h want %h", rdata, exp); end
        n_cmp++; if (porto !== 8'h3C) begin n_fail++; $display("FAIL rw_collide_porto: got %h want 3c", porto); end
        @(negedge clk);
        n_cmp++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold: got %h want a5", rdata); end
        wr(A_IN, 8'h00);
        rd(A_IN, 8'hFF);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL in_readonly: got %h want %h", rdata, exp); end
    endtask

    task automatic test_edge_irq;
        int n;
        logic prev_irq;
        wr(A_IEN, 8'h01);
        rd(A_IEN, 8'h01);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL ien_read: got %h want %h", rdata, exp); end
        porti = 8'h00; addr = A_IN; re = 1'b1;
        n = 0; prev_irq = irq;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rdata === 8'h00) break;
            prev_irq = irq;
        end
        re = 1'b0;
        n_cmp++;
        if (DEB ? (n < 2 + (LEN-1)*DIV + 2 || n > 2 + DIV*LEN + 1) : (n != 4)) begin
            n_fail++; $display("FAIL in_latency: got %0d cycles (rdata %h)", n, rdata);
        end
        n_cmp++; if (prev_irq !== 1'b0 || irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b->%b want 0->1", prev_irq, irq); end
        rd(A_EDGE, 8'hFF);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL edge_set: got %h want %h", rdata, exp); end
        wr(A_EDGE, 8'h01);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq); end
        rd(A_EDGE, 8'hFE);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL edge_w1c: got %h want %h", rdata, exp); end
        wr(A_IEN, 8'hFF);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b want 1", irq); end
        wr(A_IEN, 8'h00);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_mask: got %b want 0", irq); end
        rd(A_EDGE, 8'hFE);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL edge_kept_masked: got %h want %h", rdata, exp); end
        porti = 8'hFF;
        repeat (30) @(negedge clk);
        wr(A_EDGE, 8'hFF);
        rd(A_EDGE, 8'h00);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL edge_clear_all: got %h want %h", rdata, exp); end
    endtask

    task automatic test_glitch;
        wr(A_IEN, 8'hFF);
        porti[3] = 1'b0;
        repeat (5) @(negedge clk);
        porti[3] = 1'b1;
        repeat (30) @(negedge clk);
        rd(A_IN, 8'hFF);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL glitch_in: got %h want %h", rdata, exp); end
        rd(A_EDGE, DEB ? 8'h00 : 8'h08);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL glitch_edge: got %h want %h", rdata, exp); end
        n_cmp++; if (irq !== ~DEB) begin n_fail++; $display("FAIL glitch_irq: got %b want %b", irq, ~DEB); end
        wr(A_EDGE, 8'hFF);
        wr(A_IEN, 8'h00);
    endtask

    task automatic test_collision;
        int c0, e, t;
        c0 = cyc;
        porti[0] = 1'b0;
        if (DEB) begin
            e = c0 + 3;
            while (e % DIV != 0) e++;
            t = e + (LEN-1)*DIV;
        end else begin
            t = c0 + 3;
        end
        while (cyc != t - 1 && cyc < c0 + 100) @(negedge clk);
        wr(A_EDGE, 8'h01);
        rd(A_IN, 8'hFE);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL collide_in: got %h want %h", rdata, exp); end
        rd(A_EDGE, 8'h01);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL collide_set_wins: got %h want %h", rdata, exp); end
        wr(A_EDGE, 8'h01);
        rd(A_EDGE, 8'h00);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL w1c_plain: got %h want %h", rdata, exp); end
        porti[0] = 1'b1;
        repeat (30) @(negedge clk);
        wr(A_EDGE, 8'hFF);
    endtask

    task automatic test_reset_mid;
        int n;
        porti = 8'h00;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (porto !== 8'h00) begin n_fail++; $display("FAIL midrst_porto: got %h want 00", porto); end
        n_cmp++; if (irq !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_irq_rdata: got %b/%h want 0/00", irq, rdata); end
        @(negedge clk);
        rst_n = 1'b1; addr = A_IN; re = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rdata === 8'h00) break;
        end
        re = 1'b0;
        n_cmp++;
        if (n != (DEB ? 1 + DIV*LEN : 4)) begin
            n_fail++; $display("FAIL midrst_fresh_debounce: got %0d cycles want %0d", n, DEB ? 1 + DIV*LEN : 4);
        end
        rd(A_EDGE, 8'hFF);
        exp = exp_q.pop_front();
        n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL midrst_edge: got %h want %h", rdata, exp); end
    endtask

    initial begin
        test_reset();
        test_output();
        test_edge_irq();
        test_glitch();
        test_collision();
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised general-purpose I/O port peripheral for the picoCPU system. It is the successor to the fixed 8-bit PORTI/PORTO pair.
- Provides a WIDTH-bit output register and a WIDTH-bit input path with 2-flop synchroniser and per-bit debounce.
- Latches per-bit edge status and raises a maskable interrupt.
- Sits on the CPU's simple register bus, between the core and the chip pins.

Parameters:
- WIDTH, 8: number of port bits (1..32).
- DEB_DIV, 4: prescaler period in CLK cycles between debounce samples (>=1).
- DEB_LEN, 3: consecutive differing samples needed to accept a new input level (>=1).
- RST_OUT, all-zeros: PORTO value at reset.
- RST_IN, all-ones: debounced-input value at reset. Matches the idle-high pin level.

Ports:
- CLK, input, 1: system clock, rising edge.
- RES_N, input, 1: asynchronous active-low reset.
- ADDR, input, 2: register select.
- WE, input, 1: write strobe, one cycle.
- RE, input, 1: read strobe, one cycle.
- WDATA, input, WIDTH: write data.
- RDATA, output, WIDTH: read data. Registered, valid the cycle after RE.
- PORTI, input, WIDTH: asynchronous pin inputs.
- PORTO, output, WIDTH: pin outputs.
- IRQ, output, 1: level interrupt.

Behaviour:
- Reset (RES_N low, asynchronous; applies at any time, including mid-debounce):
  - PORTO=RST_OUT, RDATA=0, IRQ=0.
  - Synchroniser flops and stable register = RST_IN.
  - All debounce counters and the prescaler = 0.
  - EDGE_STS=0, IRQ_EN=0.
- Register map:
  - 0 OUT: read/write. Drives PORTO directly; a write appears on PORTO at the next edge.
  - 1 IN: read-only. Returns the stable (debounced) value. Writes are ignored.
  - 2 EDGE_STS: read, write-1-to-clear.
  - 3 IRQ_EN: read/write.
- Read/write collisions:
  - WE and RE in the same cycle: the write executes; RDATA returns the pre-write value.
  - RDATA holds its value when RE is low.
- Synchroniser: 2 flops per bit. sync = second flop.
- Prescaler:
  - Counts 0..DEB_DIV-1 and wraps.
  - tick is asserted for one cycle when the count equals DEB_DIV-1.
  - DEB_DIV=1 gives a tick every cycle.
- Per-bit debounce, on each tick:
  - sync == stable: cnt is reset to 0.
  - Otherwise, if cnt == DEB_LEN-1: stable <= sync and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Counter width is clog2(DEB_LEN), minimum 1 bit.
  - Worst-case pin-to-IN latency: 2 + DEB_DIV*DEB_LEN cycles.
- Edge status:
  - Any change of a stable bit sets that EDGE_STS bit in the same cycle the stable value updates.
  - W1C write and a new set on the same bit in the same cycle: set wins, bit stays 1.
- IRQ:
  - Registered: IRQ <= |(EDGE_STS & IRQ_EN), one cycle after EDGE_STS/IRQ_EN change.
  - Clearing IRQ_EN masks IRQ without clearing status.
- No other state machine: each bit's debounce is the two-state IDLE/COUNTING behaviour implied by cnt==0 vs cnt!=0.

Optional Feature:
- Macro GPIO_PORT_DEBOUNCE_EN.
- Defined: prescaler and per-bit debounce as above.
- Undefined:
  - Prescaler and counters are not built.
  - stable <= sync every cycle; pin-to-IN latency is exactly 3 cycles.
  - DEB_DIV/DEB_LEN are ignored. Edge status and IRQ operate on the undebounced synchronised value.

Test Plan (WIDTH=8, DEB_DIV=4, DEB_LEN=3, debounce enabled unless stated):
- Reset: hold RES_N=0 with PORTI=0xFF -> PORTO=0x00, IRQ=0; after release, read IN = 0xFF and EDGE_STS = 0x00.
- Output: write OUT=0xA5 -> PORTO=0xA5 next cycle; read OUT -> RDATA=0xA5 one cycle after RE.
- Debounced edge + IRQ:
  - Set IRQ_EN=0x01; PORTI 0xFF->0x00, held -> IN reads 0x00 within 14 cycles; EDGE_STS=0xFF; IRQ=1 one cycle later.
  - Write EDGE_STS=0x01 -> IRQ=0; EDGE_STS=0xFE.
- Glitch reject: pulse PORTI[3] low for 5 cycles -> IN stays 0xFF; EDGE_STS stays 0x00; IRQ stays 0.
- Collision: W1C of EDGE_STS bit0 in the same cycle bit0's stable value changes -> EDGE_STS[0]=1 afterwards.
- Reset mid-debounce: drop PORTI to 0x00, assert RES_N after 6 cycles -> all reset values restored. After release with PORTI still 0x00, IN changes to 0x00 only after a full fresh debounce interval. Repeat with the macro undefined -> IN follows PORTI 3 cycles after each change.
